// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master = producer/consumer side, slave = the adder.
`timescale 1ns/1ps
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carry_in, mode, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carry_in, mode, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH cycles per operation with valid/ready on both sides.
`timescale 1ns/1ps
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  idx_q;
  logic             carry_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;
  logic             out_valid_q;

  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shift;

  // Operand registers shift right, so bit 0 is always the bit being processed.
  always_comb begin
    bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit = (idx_q == CntW'(WIDTH - 1));
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = bit_s;
    end else begin : g_wn
      assign sum_shift = {bit_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            // Subtract as a + ~b + !borrow_in.
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.mode}};
            carry_q <= bus.carry_in ^ bus.mode;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= bit_c;
          sum_q   <= sum_shift;
          idx_q   <= idx_q + CntW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            carry_out_q <= bit_c;
            overflow_q  <= carry_q ^ bit_c;
            zero_q      <= (sum_shift == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
